// File: rtl/rate_pkg.sv
// Shared rate-tick definitions: rate codes, detector states and default divider periods.
// Imported by both the select rate divider and the tick rate detector so both ends agree.
package rate_pkg;

    localparam int unsigned CNT_W_DEF        = 27;
    localparam int unsigned PERIOD_CODE1_DEF = 2;
    localparam int unsigned PERIOD_CODE2_DEF = 4;
    localparam int unsigned PERIOD_CODE3_DEF = 8;
    localparam int unsigned TIMEOUT_DEF      = 16;
    localparam int unsigned LOCK_COUNT_DEF   = 2;

    localparam logic [1:0] RATE_NONE  = 2'd0;
    localparam logic [1:0] RATE_CODE1 = 2'd1;
    localparam logic [1:0] RATE_CODE2 = 2'd2;
    localparam logic [1:0] RATE_CODE3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Registered detector status seen by the step controller / debug display.
    typedef struct packed {
        logic [1:0] rate_code;
        logic       locked;
        logic       rate_change;
    } status_t;

endpackage

// File: rtl/tick_edge_counter.sv
// Rising-edge detect on the tick strobe plus a saturating edge-to-edge cycle counter.
module tick_edge_counter
    import rate_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             hold,
    input  logic             tick_in,
    output logic             tick_edge_c,
    output logic [CNT_W-1:0] count
);

    logic tick_q;

    assign tick_edge_c = tick_in & ~tick_q;

    // Edge history keeps sampling while disabled so a held level is never re-counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            if (tick_edge_c) begin
                count <= CNT_W'(1);
            end else if (hold) begin
                count <= '0;
            end else if (count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tick_rate_detector.sv
// Recovers the divider rate code from tick spacing: classifies edge-to-edge intervals,
// locks after LOCK_COUNT consecutive matches and drops lock on mismatch or timeout.
module tick_rate_detector
    import rate_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned PERIOD_CODE1 = PERIOD_CODE1_DEF,
    parameter int unsigned PERIOD_CODE2 = PERIOD_CODE2_DEF,
    parameter int unsigned PERIOD_CODE3 = PERIOD_CODE3_DEF,
    parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
    parameter int unsigned LOCK_COUNT   = LOCK_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick_in,
    output logic [1:0]       rate_code,
    output logic             locked,
    output logic             rate_change,
    output logic [CNT_W-1:0] interval
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 2);

    state_t             state_q, state_d;
    logic [1:0]         cand_q, cand_d;
    logic [MATCH_W-1:0] match_q, match_d;
    status_t            status_q, status_d;
    logic [CNT_W-1:0]   interval_q, interval_d;

    logic               tick_edge_c;
    logic               edge_en_c;
    logic               timeout_c;
    logic               hold_c;
    logic [1:0]         cls_c;
    logic [CNT_W-1:0]   count;

    function automatic logic [1:0] classify(input logic [CNT_W-1:0] c);
        if (c == CNT_W'(PERIOD_CODE1)) return RATE_CODE1;
        if (c == CNT_W'(PERIOD_CODE2)) return RATE_CODE2;
        if (c == CNT_W'(PERIOD_CODE3)) return RATE_CODE3;
        return RATE_NONE;
    endfunction

    assign edge_en_c = en & tick_edge_c;
    assign cls_c     = classify(count);
    // An edge on the timeout cycle takes priority.
    assign timeout_c = (state_q != IDLE) && !tick_edge_c && (count == CNT_W'(TIMEOUT));
    assign hold_c    = (state_q == IDLE) || timeout_c;

    tick_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .hold        (hold_c),
        .tick_in     (tick_in),
        .tick_edge_c (tick_edge_c),
        .count       (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cand_q     <= RATE_NONE;
            match_q    <= '0;
            status_q   <= '0;
            interval_q <= '0;
        end else if (en) begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            match_q    <= match_d;
            status_q   <= status_d;
            interval_q <= interval_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        cand_d               = cand_q;
        match_d              = match_q;
        status_d             = status_q;
        status_d.rate_change = 1'b0;
        interval_d           = interval_q;

        case (state_q)
            IDLE: begin
                if (edge_en_c) state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_en_c) begin
                    interval_d = count;
                    if (cls_c == RATE_NONE) begin
                        cand_d  = RATE_NONE;
                        match_d = '0;
                    end else if (cls_c == cand_q) begin
                        match_d = match_q + MATCH_W'(1);
                    end else begin
                        cand_d  = cls_c;
                        match_d = MATCH_W'(1);
                    end
                    if ((cls_c != RATE_NONE) && (match_d >= MATCH_W'(LOCK_COUNT))) begin
                        state_d              = LOCKED;
                        status_d.locked      = 1'b1;
                        status_d.rate_code   = cand_d;
                        status_d.rate_change = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_d              = IDLE;
                    cand_d               = RATE_NONE;
                    match_d              = '0;
                    status_d.locked      = 1'b0;
                    status_d.rate_code   = RATE_NONE;
                    status_d.rate_change = (status_q.rate_code != RATE_NONE);
                end
            end
            LOCKED: begin
                if (edge_en_c) begin
                    interval_d = count;
                    if (cls_c != status_q.rate_code) begin
                        state_d              = MEASURE;
                        cand_d               = cls_c;
                        match_d              = MATCH_W'(cls_c != RATE_NONE);
                        status_d.locked      = 1'b0;
                        status_d.rate_code   = RATE_NONE;
                        status_d.rate_change = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_d              = IDLE;
                    cand_d               = RATE_NONE;
                    match_d              = '0;
                    status_d.locked      = 1'b0;
                    status_d.rate_code   = RATE_NONE;
                    status_d.rate_change = (status_q.rate_code != RATE_NONE);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rate_code   = status_q.rate_code;
    assign locked      = status_q.locked;
    assign rate_change = status_q.rate_change;
    assign interval    = interval_q;

endmodule

// File: tb/tb_tick_rate_detector.sv
// Directed bench for tick_rate_detector: lock, relock, invalid period, timeout, enable, reset.
module tb_tick_rate_detector;

    localparam int unsigned CNT_W = 27;

    logic             clk;
    logic             reset;
    logic             en;
    logic             tick_in;
    logic [1:0]       rate_code;
    logic             locked;
    logic             rate_change;
    logic [CNT_W-1:0] interval;

    int checks;
    int failures;

    tick_rate_detector dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .tick_in     (tick_in),
        .rate_code   (rate_code),
        .locked      (locked),
        .rate_change (rate_change),
        .interval    (interval)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive tick_in for one posedge; return at the following negedge to sample outputs.
    task automatic step(input logic t);
        tick_in = t;
        @(negedge clk);
    endtask

    // Place a rising edge n cycles after the previous one.
    task automatic gap(input int n);
        repeat (n - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic check_all(input string tag, input logic [1:0] rc, input logic lk,
                             input logic ch, input logic [31:0] iv);
        check({tag, "_rate_code"}, 32'(rate_code), 32'(rc));
        check({tag, "_locked"}, 32'(locked), 32'(lk));
        check({tag, "_rate_change"}, 32'(rate_change), 32'(ch));
        check({tag, "_interval"}, 32'(interval), iv);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        en       = 1'b1;
        tick_in  = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset", 2'd0, 1'b0, 1'b0, 32'd0);
        reset = 1'b0;

        // Period 4: lock to code 2 on the third edge
        step(1'b1);
        gap(4);
        check_all("p4_e2", 2'd0, 1'b0, 1'b0, 32'd4);
        gap(4);
        check_all("p4_lock", 2'd2, 1'b1, 1'b1, 32'd4);
        step(1'b0);
        check("p4_pulse_end", 32'(rate_change), 32'd0);

        // Switch to period 8: unlock, then relock to code 3
        repeat (6) step(1'b0);
        step(1'b1);
        check_all("p8_unlock", 2'd0, 1'b0, 1'b1, 32'd8);
        gap(8);
        check_all("p8_lock", 2'd3, 1'b1, 1'b1, 32'd8);

        // Period 5 is no valid code: one unlock, then nothing
        gap(5);
        check_all("p5_unlock", 2'd0, 1'b0, 1'b1, 32'd5);
        for (int i = 0; i < 5; i++) begin
            gap(5);
            check("p5_no_change", 32'(rate_change), 32'd0);
            check("p5_no_lock", 32'(locked), 32'd0);
        end
        check_all("p5_end", 2'd0, 1'b0, 1'b0, 32'd5);

        // Period 2: lock to code 1, then stop ticking
        gap(2);
        check("p2_first", 32'(locked), 32'd0);
        gap(2);
        check_all("p2_lock", 2'd1, 1'b1, 1'b1, 32'd2);
        repeat (15) step(1'b0);
        check_all("to_before", 2'd1, 1'b1, 1'b0, 32'd2);
        step(1'b0);
        check_all("to_fire", 2'd0, 1'b0, 1'b1, 32'd2);
        step(1'b0);
        check("to_pulse_end", 32'(rate_change), 32'd0);

        // Relock at period 2, then freeze with en low
        step(1'b1);
        gap(2);
        gap(2);
        check_all("en_lock", 2'd1, 1'b1, 1'b1, 32'd2);
        step(1'b0);
        en = 1'b0;
        repeat (5) begin
            step(1'b1);
            step(1'b0);
        end
        check_all("en_frozen", 2'd1, 1'b1, 1'b0, 32'd2);
        en = 1'b1;
        step(1'b1);
        check_all("en_resume", 2'd1, 1'b1, 1'b0, 32'd2);

        // Level held high: no further edges, timeout 16 cycles after the rise
        repeat (15) step(1'b1);
        check("hi_before_to", 32'(locked), 32'd1);
        step(1'b1);
        check_all("hi_to", 2'd0, 1'b0, 1'b1, 32'd2);
        repeat (4) step(1'b1);
        check_all("hi_idle", 2'd0, 1'b0, 1'b0, 32'd2);

        // Edge exactly on the timeout count is measured, not timed out
        step(1'b0);
        step(1'b1);
        gap(16);
        check("edge_at_to_interval", 32'(interval), 32'd16);
        gap(2);
        check("after_edge_at_to", 32'(interval), 32'd2);
        gap(4);
        gap(4);
        check_all("relock_p4", 2'd2, 1'b1, 1'b1, 32'd4);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        step(1'b0);
        #2 reset = 1'b1;
        #1 check_all("async_reset", 2'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0);
        check_all("post_reset", 2'd0, 1'b0, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_rate_detector.md
Name: tick_rate_detector

Overview:
- Receiver side of the rate-tick interface: watches a single-cycle tick strobe from the select rate divider and recovers which rate code produced it.
- Measures the cycle interval between tick rising edges and classifies it against the three divider periods.
- Declares lock after repeated matching intervals and flags loss of ticks by timeout.
- Sits beside the automaton step controller for self-check and debug display. Same clock domain as the divider; no synchroniser.

Parameters:
- CNT_W, 27, width of the interval counter and of the interval output.
- PERIOD_CODE1, 2, tick interval in cycles produced by rate code 1.
- PERIOD_CODE2, 4, tick interval in cycles produced by rate code 2.
- PERIOD_CODE3, 8, tick interval in cycles produced by rate code 3.
- TIMEOUT, 16, cycles without an edge before ticks are considered stopped. Must exceed every PERIOD_CODEn.
- LOCK_COUNT, 2, consecutive equal-class intervals required to lock (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  enable; when low, all state, counters and outputs hold (edge register still samples)
- tick_in  in  1  tick strobe from the rate divider
- rate_code  out  2  locked rate code 1..3; 0 = none or unlocked
- locked  out  1  high while a rate is locked
- rate_change  out  1  one-cycle pulse whenever rate_code changes value
- interval  out  CNT_W  last measured edge-to-edge interval in cycles

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, candidate=0, match_cnt=0, tick_q=0. All outputs 0.
- Edge: edge = tick_in & ~tick_q. tick_q is registered every cycle regardless of en. A level held high counts as one edge.
- Count:
  - On an edge cycle, count<=1.
  - Otherwise count<=count+1, saturating at all-ones.
  - At edge t2 after edge t1, count = t2-t1.
- Classify (combinational on count at edge): equal to PERIOD_CODE1/2/3 -> class 1/2/3; anything else -> class 0. Exact match; no tolerance.
- Latency: interval, rate_code, locked and rate_change are registered, and update on the cycle after the edge.
- States:
  - IDLE: count held at 0. Edge -> MEASURE. No interval is produced from the first edge.
  - MEASURE, on edge: interval<=count.
    - Class 0: candidate=0, match_cnt=0.
    - Class equal to candidate: match_cnt++.
    - Otherwise: candidate=class, match_cnt=1.
    - When match_cnt reaches LOCK_COUNT: go to LOCKED, locked=1, rate_code=candidate, rate_change pulses.
  - LOCKED, on edge: interval<=count.
    - Same class: stay.
    - Different class, including 0: locked=0, rate_code=0, rate_change pulses, go to MEASURE with candidate=class and match_cnt=(class!=0).
- Timeout: in MEASURE or LOCKED, if count==TIMEOUT with no edge, go to IDLE.
  - locked=0, rate_code=0, candidate=0, match_cnt=0.
  - rate_change pulses only if rate_code was non-zero.
  - interval holds its last value.
- Simultaneous: an edge on the timeout cycle wins; it is treated as a normal edge.
- LOCK_COUNT=1: lock occurs on the first valid interval.
- Reset mid-lock: outputs clear immediately (asynchronous). No rate_change pulse is generated by reset.
- en low: edges arriving while en=0 are not measured. The count does not advance.

Decomposition:
- Shared package rate_pkg:
  - rate-code constants RATE_NONE=0, RATE_CODE1..3.
  - state encoding IDLE/MEASURE/LOCKED.
  - default period constants, shared with select_rate_divider so both ends agree.
- One natural sub-module: tick_edge_counter (edge detect plus saturating interval counter, outputs edge and count). The FSM and classifier stay in the top module.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> rate_code=0, locked=0, rate_change=0, interval=0 immediately.
- Edges every 4 cycles, three edges:
  - interval=4 after the 2nd edge;
  - after the 3rd edge, locked=1, rate_code=2, and a single rate_change pulse one cycle later.
- Locked at code 2, then switch to a period of 8:
  - first 8-interval -> locked=0, rate_code=0, rate_change pulse;
  - next 8-interval -> locked=1, rate_code=3, rate_change pulse.
- Edges every 5 cycles, repeated 6 times -> interval=5, locked stays 0, rate_code=0, no rate_change.
- Locked at code 1 (period 2), then tick_in held low -> 16 cycles after the last edge: locked=0, rate_code=0, one rate_change pulse, interval still 2.
- Period 2 stream with en=0 for 10 cycles mid-stream -> outputs frozen. tick_in held high 20 cycles -> a single edge, then timeout to IDLE.
